// File: rtl/fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// fifo_wr_arbiter
//   Round-robin burst arbiter sharing one FIFO write port among N_REQ sources.
//   Revision: 1.0
// ============================================================================
module fifo_wr_arbiter #(
  parameter int N_REQ     = 4,
  parameter int WIDTH     = 32,
  parameter int MAX_BURST = 8,
  localparam int IDW      = $clog2(N_REQ)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [N_REQ*WIDTH-1:0] req_data,
  input  logic [N_REQ-1:0]       req_last,
  output logic [N_REQ-1:0]       req_ready,
  input  logic                   fifo_full,
  output logic                   fifo_push,
  output logic [WIDTH-1:0]       fifo_data,
  output logic [IDW-1:0]         fifo_id,
  output logic                   busy
);

  localparam int CW = $clog2(MAX_BURST + 1);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_BURST = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [IDW-1:0]  grant_q, grant_d;
  logic [IDW-1:0]  last_grant_q, last_grant_d;
  logic [CW-1:0]   beat_cnt_q, beat_cnt_d;

  logic            sel_found;
  logic [IDW-1:0]  sel_idx;
  logic            xfer;

  // First valid requester after the last one served, wrapping around.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      logic [IDW-1:0] cand;
      cand = IDW'((int'(last_grant_q) + i) % N_REQ);
      if (!sel_found && req_valid[cand]) begin
        sel_found = 1'b1;
        sel_idx   = cand;
      end
    end
  end

  assign xfer = (state_q == S_BURST) && req_valid[grant_q] && !fifo_full && !rst;

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    beat_cnt_d   = beat_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (sel_found) begin
          grant_d    = sel_idx;
          beat_cnt_d = '0;
          state_d    = S_BURST;
        end
      end
      S_BURST: begin
        if (xfer) begin
          beat_cnt_d = beat_cnt_q + CW'(1);
          if (req_last[grant_q] || (beat_cnt_q == CW'(MAX_BURST - 1))) begin
            last_grant_d = grant_q;
            state_d      = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // last_grant resets to the top index so requester 0 wins the first scan.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      grant_q      <= '0;
      last_grant_q <= IDW'(N_REQ - 1);
      beat_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      beat_cnt_q   <= beat_cnt_d;
    end
  end

  always_comb begin
    req_ready = '0;
    if (!rst && (state_q == S_BURST)) begin
      req_ready[grant_q] = !fifo_full;
    end
  end

  assign fifo_push = xfer;
  assign fifo_data = req_data[int'(grant_q)*WIDTH +: WIDTH];
  assign fifo_id   = grant_q;
  assign busy      = (state_q == S_BURST);

endmodule
`default_nettype wire

// File: tb/tb_fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// tb_fifo_wr_arbiter
//   Directed self-checking bench for fifo_wr_arbiter (N_REQ=4, MAX_BURST=8).
//   Revision: 1.0
// ============================================================================
module tb_fifo_wr_arbiter;

  localparam int N  = 4;
  localparam int W  = 32;
  localparam int MB = 8;
  localparam int DEPTH = 40;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   req_last;
  logic [N-1:0]   req_ready;
  logic           fifo_full;
  logic           fifo_push;
  logic [W-1:0]   fifo_data;
  logic [1:0]     fifo_id;
  logic           busy;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int seq      = 0;

  // Per-requester beat storage: each requester presents dmem[r][head[r]].
  logic [W-1:0] dmem [N][DEPTH];
  logic         lmem [N][DEPTH];
  int           head [N];
  int           tot  [N];
  logic [N-1:0] hold;

  int           log_id   [$];
  logic [W-1:0] log_data [$];
  int           log_cyc  [$];

  fifo_wr_arbiter #(.N_REQ(N), .WIDTH(W), .MAX_BURST(MB)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ready (req_ready),
    .fifo_full (fifo_full),
    .fifo_push (fifo_push),
    .fifo_data (fifo_data),
    .fifo_id   (fifo_id),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void drive();
    for (int i = 0; i < N; i++) begin
      req_valid[i]       = (head[i] < tot[i]) && !hold[i];
      req_data[i*W +: W] = dmem[i][head[i]];
      req_last[i]        = lmem[i][head[i]];
    end
  endfunction

  function automatic bit pending();
    bit p = 1'b0;
    for (int i = 0; i < N; i++) if (head[i] < tot[i]) p = 1'b1;
    return p;
  endfunction

  task automatic load(input int r, input int n, input bit each_last);
    for (int k = 0; k < n; k++) begin
      dmem[r][tot[r]] = 32'hC000_0000 | (W'(r) << 24) | W'(seq);
      lmem[r][tot[r]] = each_last || (k == n - 1);
      tot[r]++;
      seq++;
    end
    drive();
  endtask

  // Called mid-cycle: log a push about to happen, cross the edge, retire
  // accepted beats, then present the next beats.
  task automatic tick();
    logic [N-1:0] acc;
    if (fifo_push) begin
      log_id.push_back(int'(fifo_id));
      log_data.push_back(fifo_data);
      log_cyc.push_back(cyc);
    end
    acc = req_valid & req_ready;
    @(posedge clk);
    cyc++;
    #2;
    for (int i = 0; i < N; i++) if (acc[i]) head[i]++;
    drive();
    #1;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (pending() && n < budget) begin
      tick();
      n++;
    end
    chk("drain_timeout", 64'(pending()), 64'd0);
  endtask

  task automatic clear_log();
    log_id.delete();
    log_data.delete();
    log_cyc.delete();
  endtask

  initial begin
    int b0, b1, b2, b3;
    int eid [$];
    logic [W-1:0] edat [$];

    rst       = 1'b1;
    fifo_full = 1'b0;
    hold      = '0;
    for (int i = 0; i < N; i++) begin
      head[i] = 0;
      tot[i]  = 0;
      for (int k = 0; k < DEPTH; k++) begin
        dmem[i][k] = '0;
        lmem[i][k] = 1'b0;
      end
    end

    // Reset with every requester valid: three single-beat packets each.
    for (int r = 0; r < N; r++) load(r, 3, 1'b1);
    tick();
    for (int k = 0; k < 3; k++) begin
      chk("rst_ready", 64'(req_ready), 64'd0);
      chk("rst_push",  64'(fifo_push), 64'd0);
      chk("rst_busy",  64'(busy),      64'd0);
      chk("rst_id",    64'(fifo_id),   64'd0);
      tick();
    end
    rst = 1'b0;
    #1;
    chk("post_rst_idle_push", 64'(fifo_push), 64'd0);
    chk("post_rst_idle_busy", 64'(busy),      64'd0);
    tick();
    chk("first_grant_busy",  64'(busy),      64'd1);
    chk("first_grant_push",  64'(fifo_push), 64'd1);
    chk("first_grant_id",    64'(fifo_id),   64'd0);
    chk("first_grant_ready", 64'(req_ready), 64'b0001);

    // Round-robin: ids 0,1,2,3 repeating, one push every other cycle.
    drain(200);
    chk("rr_count", 64'(log_id.size()), 64'd12);
    for (int k = 0; k < 12 && k < log_id.size(); k++) begin
      chk("rr_id",   64'(log_id[k]),   64'(k % 4));
      chk("rr_data", 64'(log_data[k]), 64'(dmem[k % 4][k / 4]));
      if (k > 0) chk("rr_spacing", 64'(log_cyc[k] - log_cyc[k-1]), 64'd2);
    end

    // Burst cap: requester 2 sends 20 beats, requester 1 joins after grant.
    clear_log();
    b2 = tot[2];
    load(2, 20, 1'b0);
    tick();
    b1 = tot[1];
    load(1, 2, 1'b0);
    drain(300);
    for (int k = 0; k < 8; k++)  begin eid.push_back(2); edat.push_back(dmem[2][b2 + k]); end
    for (int k = 0; k < 2; k++)  begin eid.push_back(1); edat.push_back(dmem[1][b1 + k]); end
    for (int k = 8; k < 20; k++) begin eid.push_back(2); edat.push_back(dmem[2][b2 + k]); end
    chk("cap_count", 64'(log_id.size()), 64'd22);
    for (int k = 0; k < 22 && k < log_id.size(); k++) begin
      chk("cap_id",   64'(log_id[k]),   64'(eid[k]));
      chk("cap_data", 64'(log_data[k]), 64'(edat[k]));
    end

    // Back-pressure: full for 5 cycles after two beats of a 6-beat burst.
    clear_log();
    b0 = tot[0];
    load(0, 6, 1'b0);
    tick();
    chk("bp_busy", 64'(busy), 64'd1);
    tick();
    tick();
    fifo_full = 1'b1;
    #1;
    for (int k = 0; k < 5; k++) begin
      chk("bp_full_push",  64'(fifo_push), 64'd0);
      chk("bp_full_ready", 64'(req_ready), 64'd0);
      chk("bp_full_id",    64'(fifo_id),   64'd0);
      chk("bp_full_busy",  64'(busy),      64'd1);
      tick();
    end
    fifo_full = 1'b0;
    #1;
    chk("bp_release_push", 64'(fifo_push), 64'd1);
    drain(100);
    chk("bp_count", 64'(log_id.size()), 64'd6);
    for (int k = 0; k < 6 && k < log_id.size(); k++) begin
      chk("bp_id",   64'(log_id[k]),   64'd0);
      chk("bp_data", 64'(log_data[k]), 64'(dmem[0][b0 + k]));
    end

    // Stalling requester: requester 1 pauses while requester 3 waits.
    clear_log();
    b1 = tot[1];
    b3 = tot[3];
    load(1, 4, 1'b0);
    load(3, 2, 1'b0);
    tick();
    tick();
    hold[1] = 1'b1;
    drive();
    #1;
    for (int k = 0; k < 10; k++) begin
      chk("stall_push",  64'(fifo_push), 64'd0);
      chk("stall_busy",  64'(busy),      64'd1);
      chk("stall_id",    64'(fifo_id),   64'd1);
      chk("stall_ready", 64'(req_ready), 64'b0010);
      tick();
    end
    hold[1] = 1'b0;
    drive();
    #1;
    drain(100);
    chk("stall_count", 64'(log_id.size()), 64'd6);
    for (int k = 0; k < 6 && k < log_id.size(); k++) begin
      chk("stall_id_seq", 64'(log_id[k]), (k < 4) ? 64'd1 : 64'd3);
      chk("stall_data", 64'(log_data[k]),
          (k < 4) ? 64'(dmem[1][b1 + k]) : 64'(dmem[3][b3 + k - 4]));
    end

    // Reset after beat 3 of a 6-beat burst from requester 2.
    clear_log();
    b2 = tot[2];
    load(2, 6, 1'b0);
    tick();
    tick();
    tick();
    tick();
    chk("mid_rst_pre_count", 64'(log_id.size()), 64'd3);
    b0 = tot[0];
    load(0, 1, 1'b1);
    rst = 1'b1;
    #1;
    chk("mid_rst_push",  64'(fifo_push), 64'd0);
    chk("mid_rst_ready", 64'(req_ready), 64'd0);
    tick();
    chk("mid_rst_busy",  64'(busy),      64'd0);
    chk("mid_rst_push2", 64'(fifo_push), 64'd0);
    chk("mid_rst_id",    64'(fifo_id),   64'd0);
    tick();
    rst = 1'b0;
    #1;
    chk("mid_rst_idle_push", 64'(fifo_push), 64'd0);
    tick();
    chk("mid_rst_regrant_id",   64'(fifo_id),   64'd0);
    chk("mid_rst_regrant_push", 64'(fifo_push), 64'd1);
    drain(100);
    chk("mid_rst_count", 64'(log_id.size()), 64'd7);
    if (log_id.size() == 7) begin
      chk("mid_rst_r0_id",   64'(log_id[3]),   64'd0);
      chk("mid_rst_r0_data", 64'(log_data[3]), 64'(dmem[0][b0]));
      for (int k = 0; k < 3; k++) begin
        chk("mid_rst_r2_id",   64'(log_id[4 + k]),   64'd2);
        chk("mid_rst_r2_data", 64'(log_data[4 + k]), 64'(dmem[2][b2 + 3 + k]));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin arbiter that shares the write port of one asynchronous FIFO among `N_REQ` requesters in the FIFO's write clock domain. Each requester presents beats on a valid/ready handshake. The arbiter grants one requester at a time for a burst, which ends on `req_last` or after `MAX_BURST` beats. It forwards the granted requester's beats to the FIFO push port together with a source-ID tag, and applies back-pressure whenever the FIFO reports full.

## Interface
- `N_REQ`, 4, number of requesters (≥2)
- `WIDTH`, 32, data width per beat
- `MAX_BURST`, 8, maximum beats per grant (≥1)
- `IDW`, `$clog2(N_REQ)` (localparam), width of source-ID tag

- `clk`  in  1  single clock; same clock as the FIFO write side
- `rst`  in  1  synchronous, active-high reset
- `req_valid`  in  N_REQ  per-requester beat valid
- `req_data`  in  N_REQ*WIDTH  requester i occupies bits [i*WIDTH +: WIDTH]
- `req_last`  in  N_REQ  per-requester end-of-packet marker, qualified by valid
- `req_ready`  out  N_REQ  per-requester beat accepted
- `fifo_full`  in  1  FIFO write-side full flag
- `fifo_push`  out  1  push strobe to the FIFO
- `fifo_data`  out  WIDTH  data to the FIFO
- `fifo_id`  out  IDW  source ID of the pushed beat; stored alongside data in a FIFO of width WIDTH+IDW
- `busy`  out  1  high while in BURST state

## Operation
- Two states: IDLE and BURST. Registered state: `state`, `grant` (IDW), `last_grant` (IDW), `beat_cnt` ($clog2(MAX_BURST+1) bits).
- **IDLE**
  - If any `req_valid` is set, select the first set index scanning from `last_grant+1` mod N_REQ, then upward with wrap.
  - Register the selection into `grant`, clear `beat_cnt`, go to BURST.
  - No beats transfer in IDLE: all `req_ready`=0 and `fifo_push`=0.
- **BURST**
  - `req_ready[grant]` = !fifo_full; all other `req_ready` = 0.
  - `fifo_push` = req_valid[grant] & !fifo_full.
  - `fifo_data` = req_data[grant]; `fifo_id` = grant (combinational pass-through).
  - A transfer is a cycle with `fifo_push`=1. Each transfer increments `beat_cnt`.
  - The burst ends on the edge of a transfer where req_last[grant]=1 or beat_cnt+1 == MAX_BURST. At that edge: `last_grant` ← `grant`, state → IDLE.
  - While the granted requester deasserts valid or the FIFO is full, the grant is held indefinitely. There is no timeout, and other requesters are not served.
- A packet longer than MAX_BURST is split. Its remainder re-arbitrates normally, so beats of different packets may interleave in the FIFO; `fifo_id` disambiguates them.
- `req_valid`/`req_last` of non-granted requesters are ignored. Requesters hold data stable until ready.
- `busy` = (state == BURST).

## Timing
- Reset values after `rst` is sampled high:
  - state=IDLE, grant=0, last_grant=N_REQ-1 (requester 0 wins first), beat_cnt=0.
  - req_ready=0, fifo_push=0, fifo_id=0, busy=0.
- While `rst`=1, `req_ready` and `fifo_push` are forced 0 combinationally. A burst in progress is abandoned with no further pushes; its accepted beats remain in the FIFO.
- Arbitration latency: a request seen in IDLE at edge k yields the first possible transfer in cycle k+1.
- There is one IDLE bubble cycle between consecutive bursts. Peak throughput is MAX_BURST beats per MAX_BURST+1 cycles.
- `fifo_full` is used combinationally in the same cycle. A full→not-full change enables a push in that same cycle.
- The FIFO accepts push only when not full, so the arbiter never pushes into a full FIFO. No beat is lost or duplicated.
- Single-beat packet (valid & last in the first BURST cycle): one transfer, then back to IDLE.

## Test plan
- **Reset:** hold rst 3 cycles with all req_valid=1 → req_ready=0, fifo_push=0, busy=0 throughout. After release, requester 0 is granted first: fifo_id=0 on the first push, 2 cycles after rst falls.
- **Round-robin fairness:** N_REQ=4, all requesters continuously valid with 1-beat packets (last=1) → fifo_id sequence 0,1,2,3,0,1… with a push every other cycle.
- **Burst cap:** MAX_BURST=8, requester 2 sends 20 beats with last only on beat 20, requester 1 is also valid → requester 2 pushes beats 1–8, then requester 1 is granted, then requester 2 resumes at beat 9. Verify data order per ID.
- **Back-pressure:** mid-burst, drive fifo_full=1 for 5 cycles → fifo_push=0 and req_ready=0 for those 5 cycles, grant unchanged. Beat count and data continue without gap or duplication once full drops.
- **Stalling requester:** the granted requester drops valid for 10 cycles while others are valid → grant held, no pushes, busy=1. The burst completes when the requester resumes and asserts last.
- **Reset mid-burst:** assert rst after beat 3 of a 6-beat burst → no push during or after reset until a new grant. last_grant=N_REQ-1, so requester 0 has priority afterward.
